// File: rtl/feistel_pkg.sv
// rtl/feistel_pkg.sv - shared encodings for the iterative Feistel cipher core
//
// Purpose: mode encodings, FSM state type and the default rotate amount used
//          by feistel_iter_core and feistel_round.
// Ports:   none (package).
// Optional feature macro used elsewhere in the bundle: FEISTEL_CHAIN_EN.

package feistel_pkg;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEFAULT_ROT = 3;

endpackage

// File: rtl/feistel_iter_core_if.sv
// rtl/feistel_iter_core_if.sv - handshake bundle between source, cipher core and sink
//
// Purpose: groups the input/output handshakes, key, mode and status of the core.
// Ports (signals):
//   in_valid/in_ready/in_data/in_key/in_mode : block request from the source
//   out_valid/out_ready/out_data             : result towards the sink
//   busy                                     : core is processing or holding a result
//   chain_clr                                : only with FEISTEL_CHAIN_EN, clears chaining value
// Modports: master (source/sink side), slave (core side).

interface feistel_iter_core_if #(
   parameter int BLOCK_W = 16,
   parameter int KEY_W   = 128
);

   logic               in_valid;
   logic               in_ready;
   logic [BLOCK_W-1:0] in_data;
   logic [KEY_W-1:0]   in_key;
   logic               in_mode;
   logic               out_valid;
   logic               out_ready;
   logic [BLOCK_W-1:0] out_data;
   logic               busy;

`ifdef FEISTEL_CHAIN_EN
   logic               chain_clr;

   modport master (
      output in_valid, in_data, in_key, in_mode, out_ready, chain_clr,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, in_key, in_mode, out_ready, chain_clr,
      output in_ready, out_valid, out_data, busy
   );
`else
   modport master (
      output in_valid, in_data, in_key, in_mode, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, in_key, in_mode, out_ready,
      output in_ready, out_valid, out_data, busy
   );
`endif

endinterface

// File: rtl/feistel_round.sv
// rtl/feistel_round.sv - one combinational Feistel round
//
// Purpose: L' = R, R' = L ^ (rotl_ROT(R ^ K) + K) mod 2^H.
// Ports:
//   l, r     in  H  current half blocks
//   k        in  H  round key
//   l_next   out H  next left half
//   r_next   out H  next right half

module feistel_round #(
   parameter int H   = 8,
   parameter int ROT = 3
) (
   input  logic [H-1:0] l,
   input  logic [H-1:0] r,
   input  logic [H-1:0] k,
   output logic [H-1:0] l_next,
   output logic [H-1:0] r_next
);

   logic [H-1:0] mix;
   logic [H-1:0] rot;
   logic [H-1:0] f;

   assign mix = r ^ k;

   // A zero rotate would otherwise need a full-width right shift.
   generate
      if (ROT == 0) begin : g_no_rot
         assign rot = mix;
      end else begin : g_rot
         assign rot = (mix << ROT) | (mix >> (H - ROT));
      end
   endgenerate

   assign f      = rot + k;
   assign l_next = r;
   assign r_next = l ^ f;

endmodule

// File: rtl/feistel_iter_core.sv
// rtl/feistel_iter_core.sv - iterative Feistel cipher, one round per clock
//
// Purpose: accepts a block plus key and mode, runs ROUNDS rounds through a
//          single reused feistel_round, then presents the swapped result until
//          the sink takes it. No overlap between blocks.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  feistel_iter_core_if.slave : in_valid/in_ready/in_data/in_key/in_mode,
//        out_valid/out_ready/out_data, busy (and chain_clr with FEISTEL_CHAIN_EN)
// Optional feature macro: FEISTEL_CHAIN_EN (CBC chaining register).

module feistel_iter_core
   import feistel_pkg::*;
#(
   parameter int BLOCK_W = 16,
   parameter int ROUNDS  = 16,
   parameter int ROT     = DEFAULT_ROT
) (
   input logic               clk,
   input logic               rst,
   feistel_iter_core_if.slave bus
);

   localparam int H     = BLOCK_W / 2;
   localparam int KEY_W = ROUNDS * H;
   localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

   state_t             state;
   state_t             state_next;
   logic [H-1:0]       l_q;
   logic [H-1:0]       r_q;
   logic [H-1:0]       l_nx;
   logic [H-1:0]       r_nx;
   logic [H-1:0]       rk;
   logic [KEY_W-1:0]   key_q;
   logic               mode_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [BLOCK_W-1:0] out_data_q;
   logic [BLOCK_W-1:0] blk_in;
   logic [BLOCK_W-1:0] result;
   logic               accept;
   logic               last_round;

   assign accept     = (state == ST_IDLE) && bus.in_valid;
   assign last_round = (state == ST_RUN) && (cnt_q == LAST);

   // The captured key is shifted one round key per cycle: encrypt consumes
   // from the low end, decrypt from the high end, so the active key always
   // sits at a fixed position.
   assign rk = (mode_q == MODE_DEC) ? key_q[KEY_W-1 -: H] : key_q[H-1:0];

   feistel_round #(
      .H   (H),
      .ROT (ROT)
   ) u_round (
      .l      (l_q),
      .r      (r_q),
      .k      (rk),
      .l_next (l_nx),
      .r_next (r_nx)
   );

`ifdef FEISTEL_CHAIN_EN
   logic [BLOCK_W-1:0] cv_q;
   logic [BLOCK_W-1:0] din_q;
   logic [BLOCK_W-1:0] cv_eff;

   // A clear in the same cycle as an accept applies to that block.
   assign cv_eff = bus.chain_clr ? '0 : cv_q;
   assign blk_in = (bus.in_mode == MODE_ENC) ? (bus.in_data ^ cv_eff) : bus.in_data;
   assign result = (mode_q == MODE_DEC) ? ({r_nx, l_nx} ^ cv_q) : {r_nx, l_nx};

   always_ff @(posedge clk) begin
      if (rst) begin
         cv_q  <= '0;
         din_q <= '0;
      end else begin
         if ((state == ST_IDLE) && bus.chain_clr) begin
            cv_q <= '0;
         end
         if (accept) begin
            din_q <= bus.in_data;
         end
         if (last_round) begin
            cv_q <= (mode_q == MODE_DEC) ? din_q : result;
         end
      end
   end
`else
   assign blk_in = bus.in_data;
   assign result = {r_nx, l_nx};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Handshake outputs come from the registered state only, so out_valid has
   // no combinational path from out_ready.
   always_comb begin
      state_next    = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            bus.busy = 1'b1;
            if (cnt_q == LAST) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         l_q        <= '0;
         r_q        <= '0;
         key_q      <= '0;
         mode_q     <= MODE_ENC;
         cnt_q      <= '0;
         out_data_q <= '0;
      end else if (accept) begin
         l_q    <= blk_in[BLOCK_W-1:H];
         r_q    <= blk_in[H-1:0];
         key_q  <= bus.in_key;
         mode_q <= bus.in_mode;
         cnt_q  <= '0;
      end else if (state == ST_RUN) begin
         l_q   <= l_nx;
         r_q   <= r_nx;
         key_q <= (mode_q == MODE_DEC) ? (key_q << H) : (key_q >> H);
         if (last_round) begin
            cnt_q      <= '0;
            out_data_q <= result;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.out_data = out_data_q;

endmodule

// File: tb/tb_feistel_iter_core.sv
// tb/tb_feistel_iter_core.sv - self-checking bench for feistel_iter_core

module tb_feistel_iter_core;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   localparam logic [127:0] KEY_MAIN = 128'h3F8A92B7_D4C1E609_F1AB34CD_7E58A3F2;

   feistel_iter_core_if #(.BLOCK_W(16), .KEY_W(128)) bus ();
   feistel_iter_core_if #(.BLOCK_W(16), .KEY_W(8))   sbus ();

   feistel_iter_core #(.BLOCK_W(16), .ROUNDS(16), .ROT(3)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   feistel_iter_core #(.BLOCK_W(16), .ROUNDS(1), .ROT(3)) u_small (
      .clk (clk),
      .rst (rst),
      .bus (sbus)
   );

   always #5 clk = ~clk;

   // chaining value tracked by the reference model
   logic [15:0] mcv = 16'h0;

   function automatic logic [15:0] feistel_ref(input logic [15:0] blk, input logic [127:0] key,
                                               input logic dec, input int rounds);
      logic [7:0] l, r, k, t, f, tmp;
      int ki;
      l = blk[15:8];
      r = blk[7:0];
      for (int i = 0; i < rounds; i++) begin
         ki  = dec ? (rounds - 1 - i) : i;
         k   = 8'((key >> (8 * ki)) & 128'hFF);
         t   = r ^ k;
         f   = (t << 3) | (t >> 5);
         f   = f + k;
         tmp = l ^ f;
         l   = r;
         r   = tmp;
      end
      return {r, l};
   endfunction

   // Reference for one complete block on the default-parameter core.
   function automatic logic [15:0] ref_block(input logic dec, input logic [15:0] data,
                                             input logic [127:0] key);
      logic [15:0] o;
`ifdef FEISTEL_CHAIN_EN
      if (!dec) begin
         o   = feistel_ref(data ^ mcv, key, 1'b0, 16);
         mcv = o;
      end else begin
         o   = feistel_ref(data, key, 1'b1, 16) ^ mcv;
         mcv = data;
      end
`else
      o = feistel_ref(data, key, dec, 16);
`endif
      return o;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one block on the main core with out_ready high; optionally disturbs
   // in_key right after the accept.
   task automatic run_block(input logic dec, input logic [15:0] data, input logic [127:0] key,
                            input bit key_flip, output logic [15:0] res);
      logic [15:0] exp;
      int cyc;
      exp          = ref_block(dec, data, key);
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      bus.in_key   = key;
      bus.in_mode  = dec;
      check("in_ready_idle", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      if (key_flip) bus.in_key = ~key;
      check("busy_run", bus.busy, 1);
      cyc = 0;
      while (!bus.out_valid && cyc < 100) begin
         tick();
         cyc++;
      end
      check("latency", cyc, 16);
      check("out_data", bus.out_data, exp);
      res = bus.out_data;
      tick();
      check("out_valid_drop", bus.out_valid, 0);
   endtask

   logic [15:0] words [5] = '{16'h6865, 16'h6C6C, 16'h6F77, 16'h6F72, 16'h6C64};
   logic [15:0] ct     [5];
   logic [15:0] pt;
   logic [15:0] exp_bp;
   logic [15:0] r_data;
   logic [127:0] r_key;
   logic         r_mode;
   int           cyc;
   bit           seen;

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_key    = '0;
      bus.in_mode   = 1'b0;
      bus.out_ready = 1'b1;
      sbus.in_valid = 1'b0;
      sbus.in_data  = '0;
      sbus.in_key   = '0;
      sbus.in_mode  = 1'b0;
      sbus.out_ready = 1'b1;
`ifdef FEISTEL_CHAIN_EN
      bus.chain_clr  = 1'b0;
      sbus.chain_clr = 1'b0;
`endif
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // reset state
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_small_in_ready", sbus.in_ready, 1);

      // single-round core: "he" with zero key
      sbus.in_valid = 1'b1;
      sbus.in_data  = 16'h6865;
      sbus.in_key   = 8'h00;
      sbus.in_mode  = 1'b0;
      tick();
      sbus.in_valid = 1'b0;
      check("small_not_yet", sbus.out_valid, 0);
      tick();
      check("small_valid_1cyc", sbus.out_valid, 1);
      check("small_out_data", sbus.out_data, 16'h4365);
      check("small_model", sbus.out_data, feistel_ref(16'h6865, 128'h0, 1'b0, 1));
      tick();
      check("small_release", sbus.out_valid, 0);

      // text words: encrypt then decrypt each
      for (int i = 0; i < 5; i++) begin
         run_block(1'b0, words[i], KEY_MAIN, 1'b0, ct[i]);
         run_block(1'b1, ct[i], KEY_MAIN, 1'b0, pt);
`ifndef FEISTEL_CHAIN_EN
         check("roundtrip", pt, words[i]);
`endif
      end

      // random blocks, keys and modes
      for (int i = 0; i < 6; i++) begin
         r_data = 16'($urandom);
         r_key  = {$urandom, $urandom, $urandom, $urandom};
         r_mode = 1'($urandom_range(0, 1));
         run_block(r_mode, r_data, r_key, 1'b0, pt);
      end

      // backpressure: hold the result for 5 cycles, ignore a stray request
      bus.out_ready = 1'b0;
      exp_bp        = ref_block(1'b0, 16'h1234, KEY_MAIN);
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'h1234;
      bus.in_key    = KEY_MAIN;
      bus.in_mode   = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      cyc = 0;
      while (!bus.out_valid && cyc < 100) begin
         tick();
         cyc++;
      end
      check("bp_latency", cyc, 16);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = (i == 2);
         bus.in_data  = 16'hBEEF;
         tick();
         check("bp_out_data_stable", bus.out_data, exp_bp);
         check("bp_in_ready_low", bus.in_ready, 0);
         check("bp_out_valid_held", bus.out_valid, 1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("bp_release", bus.out_valid, 0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.out_valid || bus.busy) seen = 1'b1;
      end
      check("bp_no_extra_result", seen, 0);

      // reset in the middle of round 7
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hA5C3;
      bus.in_key   = KEY_MAIN;
      bus.in_mode  = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      repeat (7) tick();
      check("mid_busy", bus.busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mcv = 16'h0;
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_out_data", bus.out_data, 0);
      check("mid_rst_in_ready", bus.in_ready, 1);
      check("mid_rst_busy", bus.busy, 0);
      run_block(1'b0, 16'h6865, KEY_MAIN, 1'b0, pt);

      // key change after accept has no effect
      run_block(1'b0, 16'h7A7A, KEY_MAIN, 1'b1, pt);

`ifdef FEISTEL_CHAIN_EN
      // chaining: identical plaintexts give different ciphertexts
      bus.chain_clr = 1'b1;
      tick();
      bus.chain_clr = 1'b0;
      mcv = 16'h0;
      run_block(1'b0, 16'h5555, KEY_MAIN, 1'b0, ct[0]);
      run_block(1'b0, 16'h5555, KEY_MAIN, 1'b0, ct[1]);
      check("chain_ct_differ", (ct[0] != ct[1]), 1);
      bus.chain_clr = 1'b1;
      tick();
      bus.chain_clr = 1'b0;
      mcv = 16'h0;
      run_block(1'b1, ct[0], KEY_MAIN, 1'b0, pt);
      check("chain_pt0", pt, 16'h5555);
      run_block(1'b1, ct[1], KEY_MAIN, 1'b0, pt);
      check("chain_pt1", pt, 16'h5555);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
